// File: rtl/uart_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_arb_pkg
// Description : Shared definitions for the UART transmit arbiter slice:
//               state encoding, parameter defaults, baud constants used by
//               the transmit shifter, and the grant-index width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_arb_pkg;

    // Arbiter state encoding (1-bit state register)
    localparam logic [0:0] c_IDLE = 1'b0;   // no grant held
    localparam logic [0:0] c_LOCK = 1'b1;   // grant held until last byte

    // Parameter defaults
    localparam int c_NUM_REQ_DEF        = 4;
    localparam int c_TIMEOUT_CYCLES_DEF = 100000;

    // Serial line timing shared with the transmit shifter
    localparam int c_CLK_HZ   = 100_000_000;
    localparam int c_BAUD     = 115_200;
    localparam int c_BAUD_DIV = c_CLK_HZ / c_BAUD;

    // Width of a requester index; never narrower than one bit
    function automatic int calc_id_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rr_picker.sv
`default_nettype none
// ============================================================================
// Module      : uart_rr_picker
// Description : Combinational rotating priority encoder. Finds the first set
//               bit of req starting at position ptr, wrapping modulo NUM_REQ.
// Ports       : req   in  NUM_REQ  request vector
//               ptr   in  ID_W     starting position (must be < NUM_REQ)
//               found out 1        at least one request bit set
//               idx   out ID_W     index of the winning request
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rr_picker
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ = c_NUM_REQ_DEF,
    parameter int ID_W    = calc_id_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic               found,
    output logic [ID_W-1:0]    idx
);

    // Bit k of w_rot is req[(ptr + k) mod NUM_REQ]; doubling the vector lets a
    // plain shift perform the wrap for any NUM_REQ, not just powers of two.
    logic [NUM_REQ-1:0] w_rot;
    logic [ID_W-1:0]    w_off;
    logic [ID_W:0]      w_sum;

    assign w_rot = NUM_REQ'({req, req} >> ptr);

    always_comb begin
        found = 1'b0;
        w_off = '0;
        // Descending scan: the last hit written is the lowest offset
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                found = 1'b1;
                w_off = ID_W'(k);
            end
        end
        // Map the rotated offset back to an absolute index
        w_sum = {1'b0, ptr} + {1'b0, w_off};
        if (w_sum >= (ID_W + 1)'(NUM_REQ)) begin
            w_sum = w_sum - (ID_W + 1)'(NUM_REQ);
        end
        idx = w_sum[ID_W-1:0];
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_arbiter
// Description : Round-robin, packet-locked arbiter sharing one byte-level UART
//               transmitter among NUM_REQ requesters. A grant is held until
//               the owner's last byte is accepted, so packets never interleave.
//               Optional idle timeout: define UART_TX_ARB_TIMEOUT_EN.
// Ports       : clk           in  1          system clock
//               rst           in  1          asynchronous active-high reset
//               req_valid     in  NUM_REQ    per-requester byte valid
//               req_data      in  8*NUM_REQ  requester i on [8i+7:8i]
//               req_last      in  NUM_REQ    end-of-packet, qualified by valid
//               req_ready     out NUM_REQ    byte accepted this cycle
//               tx_valid      out 1          byte valid toward transmitter
//               tx_data       out 8          byte toward transmitter
//               tx_ready      in  1          transmitter accepts a byte
//               grant_id      out ID_W       current owner index
//               busy          out 1          grant held
//               timeout_pulse out 1          forced release strobe
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter  int NUM_REQ        = c_NUM_REQ_DEF,
    parameter  int TIMEOUT_CYCLES = c_TIMEOUT_CYCLES_DEF,
    localparam int ID_W           = calc_id_w(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 tx_valid,
    output logic [7:0]           tx_data,
    input  logic                 tx_ready,
    output logic [ID_W-1:0]      grant_id,
    output logic                 busy,
    output logic                 timeout_pulse
);

    generate
        if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
            $error("uart_tx_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES >= 1");
        end
    endgenerate

    logic [0:0]      r_state;
    logic [ID_W-1:0] r_grant_id;
    logic [ID_W-1:0] r_rr_ptr;

    logic            w_found;
    logic [ID_W-1:0] w_win_idx;
    logic            w_owner_valid;
    logic            w_owner_last;
    logic [7:0]      w_owner_data;
    logic            w_xfer;
    logic            w_timeout;
    logic [ID_W-1:0] w_next_ptr;

    uart_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_picker (
        .req   (req_valid),
        .ptr   (r_rr_ptr),
        .found (w_found),
        .idx   (w_win_idx)
    );

    // Owner lane selection and forwarding, purely from registered state
    always_comb begin
        w_owner_valid = 1'b0;
        w_owner_last  = 1'b0;
        w_owner_data  = 8'h00;
        req_ready     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_grant_id == ID_W'(i)) begin
                w_owner_valid = req_valid[i];
                w_owner_last  = req_last[i];
                w_owner_data  = req_data[8*i +: 8];
                req_ready[i]  = busy & tx_ready;
            end
        end
    end

    assign busy     = (r_state == c_LOCK);
    assign tx_valid = busy & w_owner_valid;
    assign tx_data  = busy ? w_owner_data : 8'h00;
    assign grant_id = r_grant_id;
    assign w_xfer   = tx_valid & tx_ready;

    assign w_next_ptr = (r_grant_id == ID_W'(NUM_REQ - 1)) ? '0 : r_grant_id + 1'b1;

`ifdef UART_TX_ARB_TIMEOUT_EN
    localparam int c_CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [c_CNT_W-1:0] r_idle_cnt;
    logic               r_timeout_pulse;

    // Fires on the cycle that would bring the idle count to TIMEOUT_CYCLES.
    // It needs owner valid low, so it can never coincide with a transfer.
    assign w_timeout = busy && !w_owner_valid &&
                       (r_idle_cnt == c_CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idle_cnt      <= '0;
            r_timeout_pulse <= 1'b0;
        end else begin
            r_timeout_pulse <= w_timeout;
            if (!busy || w_owner_valid || w_timeout) begin
                r_idle_cnt <= '0;
            end else begin
                r_idle_cnt <= r_idle_cnt + 1'b1;
            end
        end
    end

    assign timeout_pulse = r_timeout_pulse;
`else
    assign w_timeout     = 1'b0;
    assign timeout_pulse = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= c_IDLE;
            r_grant_id <= '0;
            r_rr_ptr   <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    // No byte is accepted here; the first transfer happens
                    // in LOCK, one cycle after the request was seen.
                    if (w_found) begin
                        r_grant_id <= w_win_idx;
                        r_state    <= c_LOCK;
                    end
                end
                c_LOCK: begin
                    if ((w_xfer && w_owner_last) || w_timeout) begin
                        r_rr_ptr <= w_next_ptr;
                        r_state  <= c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_arbiter
// Description : Self-checking bench for uart_tx_arbiter (NUM_REQ=4,
//               TIMEOUT_CYCLES=16): directed vector table, hand-written
//               multi-cycle sequences and randomized traffic compared against
//               a behavioural reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

    localparam int N   = 4;
    localparam int T   = 16;
    localparam int IDW = 2;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req_valid = '0;
    logic [8*N-1:0] req_data = '0;
    logic [N-1:0]   req_last = '0;
    logic [N-1:0]   req_ready;
    logic           tx_valid;
    logic [7:0]     tx_data;
    logic           tx_ready = 1'b0;
    logic [IDW-1:0] grant_id;
    logic           busy;
    logic           timeout_pulse;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NUM_REQ        (N),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_last      (req_last),
        .req_ready     (req_ready),
        .tx_valid      (tx_valid),
        .tx_data       (tx_data),
        .tx_ready      (tx_ready),
        .grant_id      (grant_id),
        .busy          (busy),
        .timeout_pulse (timeout_pulse)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: owner < 0 means no grant is held
    int m_owner, m_gid, m_ptr, m_cnt;
    bit m_pulse;

    // Observed grant history
    int gq[$];
    int gaps[$];
    bit prev_busy;
    int low_run;

    typedef struct {
        logic [N-1:0]   v;
        logic [8*N-1:0] d;
        logic [N-1:0]   l;
        logic           r;
        logic           ev;
        logic [7:0]     ed;
        logic [N-1:0]   er;
        logic [IDW-1:0] eg;
        logic           eb;
    } vec_t;

    vec_t tbl[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // {tx_valid, tx_data, req_ready, grant_id, busy, timeout_pulse}
    function automatic logic [16:0] dut_out();
        return {tx_valid, tx_data, req_ready, grant_id, busy, timeout_pulse};
    endfunction

    function automatic logic [16:0] model_out();
        logic         ev;
        logic [7:0]   ed;
        logic [N-1:0] er;
        ev = 1'b0;
        ed = 8'h00;
        er = '0;
        if (m_owner >= 0) begin
            ev = req_valid[m_owner];
            ed = req_data[8*m_owner +: 8];
            er[m_owner] = tx_ready;
        end
        return {ev, ed, er, m_gid[IDW-1:0], (m_owner >= 0), m_pulse};
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_gid   = 0;
        m_ptr   = 0;
        m_cnt   = 0;
        m_pulse = 1'b0;
    endtask

    // Advance the model by one clock using the inputs currently applied
    task automatic model_step();
        m_pulse = 1'b0;
        if (m_owner < 0) begin
            for (int k = 0; k < N; k++) begin
                if (req_valid[(m_ptr + k) % N]) begin
                    m_owner = (m_ptr + k) % N;
                    m_gid   = m_owner;
                    m_cnt   = 0;
                    break;
                end
            end
        end else if (req_valid[m_owner] && tx_ready && req_last[m_owner]) begin
            m_ptr   = (m_owner + 1) % N;
            m_owner = -1;
            m_cnt   = 0;
        end else begin
`ifdef UART_TX_ARB_TIMEOUT_EN
            if (req_valid[m_owner]) begin
                m_cnt = 0;
            end else begin
                m_cnt++;
                if (m_cnt == T) begin
                    m_ptr   = (m_owner + 1) % N;
                    m_owner = -1;
                    m_cnt   = 0;
                    m_pulse = 1'b1;
                end
            end
`endif
        end
    endtask

    task automatic drive(input logic [N-1:0] v, input logic [8*N-1:0] d,
                         input logic [N-1:0] l, input logic r);
        req_valid = v;
        req_data  = d;
        req_last  = l;
        tx_ready  = r;
    endtask

    // Entered and left at posedge+1; outputs compared at the negedge
    task automatic cycle(input string name);
        @(negedge clk);
        check(name, 32'(dut_out()), 32'(model_out()));
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic track_clear();
        gq.delete();
        gaps.delete();
        prev_busy = 1'b0;
        low_run   = 0;
    endtask

    task automatic track();
        if (busy && !prev_busy) begin
            gq.push_back(int'(grant_id));
            if (gq.size() > 1) gaps.push_back(low_run);
        end
        if (busy) low_run = 0;
        else      low_run++;
        prev_busy = busy;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive('0, '0, '0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        check("reset_state", 32'(dut_out()), 32'h0);
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        logic [16:0] e;
        int b0, b3, b1, pulses;

        // ---------------- directed vector table ----------------
        //         v        d             l        r     ev    ed     er       eg    eb
        tbl[0]  = '{4'b0100, 32'h00A1_0000, 4'b0000, 1'b1, 1'b0, 8'h00, 4'b0000, 2'd0, 1'b0};
        tbl[1]  = '{4'b0100, 32'h00A1_0000, 4'b0000, 1'b1, 1'b1, 8'hA1, 4'b0100, 2'd2, 1'b1};
        tbl[2]  = '{4'b0100, 32'h00A2_0000, 4'b0000, 1'b1, 1'b1, 8'hA2, 4'b0100, 2'd2, 1'b1};
        tbl[3]  = '{4'b0100, 32'h00A3_0000, 4'b0100, 1'b1, 1'b1, 8'hA3, 4'b0100, 2'd2, 1'b1};
        tbl[4]  = '{4'b0000, 32'h0000_0000, 4'b0000, 1'b1, 1'b0, 8'h00, 4'b0000, 2'd2, 1'b0};
        tbl[5]  = '{4'b1001, 32'hC000_00B0, 4'b1001, 1'b1, 1'b0, 8'h00, 4'b0000, 2'd2, 1'b0};
        tbl[6]  = '{4'b1001, 32'hC000_00B0, 4'b1001, 1'b1, 1'b1, 8'hC0, 4'b1000, 2'd3, 1'b1};
        tbl[7]  = '{4'b1001, 32'hC000_00B0, 4'b1001, 1'b1, 1'b0, 8'h00, 4'b0000, 2'd3, 1'b0};
        tbl[8]  = '{4'b1001, 32'hC000_00B0, 4'b1001, 1'b1, 1'b1, 8'hB0, 4'b0001, 2'd0, 1'b1};
        tbl[9]  = '{4'b0010, 32'h0000_D000, 4'b0000, 1'b0, 1'b0, 8'h00, 4'b0000, 2'd0, 1'b0};
        tbl[10] = '{4'b1010, 32'hE000_D000, 4'b0000, 1'b0, 1'b1, 8'hD0, 4'b0000, 2'd1, 1'b1};
        tbl[11] = '{4'b0010, 32'h0000_D100, 4'b0010, 1'b1, 1'b1, 8'hD1, 4'b0010, 2'd1, 1'b1};
        tbl[12] = '{4'b0000, 32'h0000_0000, 4'b0000, 1'b1, 1'b0, 8'h00, 4'b0000, 2'd1, 1'b0};

        do_reset();
        for (int i = 0; i < 13; i++) begin
            drive(tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].r);
            @(negedge clk);
            check($sformatf("table_row%0d", i), 32'(dut_out()),
                  32'({tbl[i].ev, tbl[i].ed, tbl[i].er, tbl[i].eg, tbl[i].eb, 1'b0}));
            @(posedge clk);
            model_step();
            #1;
        end

        // ---------------- reset mid-packet (pointer is 2 here) ----------------
        drive(4'b0010, 32'h0000_2100, 4'b0000, 1'b1);
        cycle("rstpkt_grant");
        cycle("rstpkt_byte1");
        drive(4'b0010, 32'h0000_2200, 4'b0000, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check("rst_async_outputs", 32'({busy, tx_valid, req_ready}), 32'h0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(4'b1001, 32'h3100_0001, 4'b1001, 1'b1);
        cycle("rstpkt_idle");
        check("rst_restart_grant", 32'({grant_id, busy}), 32'({2'd0, 1'b1}));
        cycle("rstpkt_lock");

        // ---------------- fairness: req 0 and req 3, 2-byte packets ----------------
        do_reset();
        track_clear();
        b0 = 0;
        b3 = 0;
        for (int c = 0; c < 40; c++) begin
            drive(4'b1001, {8'h30 + 8'(b3), 16'h0, 8'h00 + 8'(b0)},
                  {b3[0], 2'b00, b0[0]}, 1'b1);
            e = model_out();
            cycle("fair");
            if (e[4]) b0++;
            if (e[7]) b3++;
            track();
        end
        check("fair_packet_count", 32'(gq.size() >= 4), 32'd1);
        for (int k = 0; k < 4 && k < gq.size(); k++)
            check($sformatf("fair_grant%0d", k), 32'(gq[k]), (k % 2) ? 32'd3 : 32'd0);
        for (int k = 0; k < 3 && k < gaps.size(); k++)
            check($sformatf("fair_bubble%0d", k), 32'(gaps[k]), 32'd1);

        // ---------------- no interleave under toggling backpressure ----------------
        do_reset();
        track_clear();
        b1 = 0;
        for (int c = 0; c < 20; c++) begin
            drive({1'b0, 1'b0, (b1 < 4), (c >= 1)},
                  {16'h0, 8'h10 + 8'(b1), 8'h55},
                  {2'b00, (b1 == 3), 1'b1}, (c % 2) == 0);
            e = model_out();
            cycle("nointerleave");
            if (e[5] && req_valid[1]) b1++;
            track();
        end
        check("noint_first_owner", 32'(gq.size() > 0 ? gq[0] : -1), 32'd1);
        check("noint_second_owner", 32'(gq.size() > 1 ? gq[1] : -1), 32'd0);
        check("noint_req1_bytes", 32'(b1), 32'd4);

`ifdef UART_TX_ARB_TIMEOUT_EN
        // ---------------- timeout: owner silent for T cycles ----------------
        do_reset();
        track_clear();
        pulses = 0;
        drive(4'b0100, 32'h0077_0000, 4'b0000, 1'b1);
        repeat (2) begin cycle("to_start"); track(); end
        drive(4'b0010, 32'h0000_1100, 4'b0010, 1'b1);
        for (int c = 0; c < 20; c++) begin
            cycle("to_drop16");
            if (timeout_pulse) pulses++;
            track();
        end
        check("to_pulse_count", 32'(pulses), 32'd1);
        check("to_next_owner", 32'(gq.size() > 1 ? gq[1] : -1), 32'd1);

        // ---------------- 15 silent cycles, then a byte: no timeout ----------------
        do_reset();
        pulses = 0;
        drive(4'b0100, 32'h0077_0000, 4'b0000, 1'b1);
        repeat (2) cycle("to15_start");
        drive(4'b0000, 32'h0, 4'b0000, 1'b1);
        repeat (15) begin cycle("to15_drop"); if (timeout_pulse) pulses++; end
        drive(4'b0100, 32'h0078_0000, 4'b0100, 1'b1);
        cycle("to15_last");
        if (timeout_pulse) pulses++;
        drive(4'b0000, 32'h0, 4'b0000, 1'b1);
        repeat (3) begin cycle("to15_after"); if (timeout_pulse) pulses++; end
        check("to15_no_pulse", 32'(pulses), 32'd0);
`endif

        // ---------------- randomized traffic against the model ----------------
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            if (c < 750) drive(N'($urandom), $urandom, N'($urandom & $urandom),
                               ($urandom_range(0, 3) != 0));
            else         drive(N'($urandom & $urandom & $urandom), $urandom,
                               N'($urandom & $urandom), ($urandom_range(0, 3) != 0));
            cycle("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
